// File: rtl/fifo_pixel_reader.sv
// fifo_pixel_reader: read-side consumer of the worker->VGA result FIFO.
// Each FIFO word is one pixel's iteration count. The word is mapped to a colour
// and offered to the VGA driver over a valid/ready handshake. The block also
// tracks the raster position and raises a sticky flag on underruns.
// Optional feature macro: PIXEL_COORD_EN. When it is defined, the pixel_x,
// pixel_y and frame_end counters are built. When it is not defined, those
// outputs are tied to zero.
module fifo_pixel_reader #(
  parameter int BIT_WIDTH    = 32,
  parameter int COLOUR_WIDTH = 16,
  parameter int MAX_ITER     = 255,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [BIT_WIDTH-1:0]       fifo_data,
  output logic                       fifo_rd,
  input  logic                       pixel_ready,
  output logic                       pixel_valid,
  output logic [COLOUR_WIDTH-1:0]    pixel_colour,
  output logic [$clog2(H_RES)-1:0]   pixel_x,
  output logic [$clog2(V_RES)-1:0]   pixel_y,
  output logic                       frame_end,
  output logic                       underrun
);

  localparam logic [BIT_WIDTH-1:0] MAX_ITER_W = BIT_WIDTH'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   armed;

  // Counts at or above MAX_ITER are inside the set and are shown as black.
  // Other counts pass through, truncated or zero-extended to the colour width.
  function automatic logic [COLOUR_WIDTH-1:0] map_colour(input logic [BIT_WIDTH-1:0] word);
    if (word >= MAX_ITER_W) begin
      return '0;
    end
    return COLOUR_WIDTH'(word);
  endfunction

  assign accept = pixel_valid & pixel_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read strobe. No read can issue while in reset, so a
  // FIFO word is never popped and then lost to the reset.
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          fifo_rd = !fifo_empty;
          if (!fifo_empty) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          state_next = VALID;
        end
        VALID: begin
          if (pixel_ready) begin
            fifo_rd    = !fifo_empty;
            state_next = fifo_empty ? IDLE : WAIT;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Capture the FIFO word in the cycle after the read, and hold it until it is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid  <= 1'b0;
      pixel_colour <= '0;
    end else if (state == WAIT) begin
      pixel_valid  <= 1'b1;
      pixel_colour <= map_colour(fifo_data);
    end else if (accept) begin
      pixel_valid  <= 1'b0;
    end
  end

  // Underrun arms on the first accepted pixel. After that, it latches any ready seen with no valid pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (accept) begin
        armed <= 1'b1;
      end
      if (armed && pixel_ready && !pixel_valid) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef PIXEL_COORD_EN
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  // Raster position of the presented pixel. It advances on accept and raises frame_end after the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x   <= '0;
      pixel_y   <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (accept) begin
        if (pixel_x == X_LAST) begin
          pixel_x <= '0;
          if (pixel_y == Y_LAST) begin
            pixel_y   <= '0;
            frame_end <= 1'b1;
          end else begin
            pixel_y <= pixel_y + 1'b1;
          end
        end else begin
          pixel_x <= pixel_x + 1'b1;
        end
      end
    end
  end
`else
  assign pixel_x   = '0;
  assign pixel_y   = '0;
  assign frame_end = 1'b0;
`endif

endmodule
